// File: rtl/tail_light_pkg.sv
// Shared types for the tail-light sequencer: controller states and the
// prioritised request encoding seen by the next-state logic.
package tail_light_pkg;

  // Controller states; encodings 6 and 7 are unused and recover to IDLE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEFT    = 3'd1,
    RIGHT   = 3'd2,
    DARK    = 3'd3,
    HAZ_ON  = 3'd4,
    HAZ_OFF = 3'd5
  } state_e;

  // Driver request after priority resolution.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_L    = 2'd1,
    REQ_R    = 2'd2,
    REQ_HAZ  = 2'd3
  } req_e;

  // Hazard wins, and so does a simultaneous left+right request
  // (a driver holding both stalks is treated as asking for hazards).
  function automatic req_e decode_req(input logic left_s,
                                      input logic right_s,
                                      input logic hazard_s);
    req_e req;
    if (hazard_s || (left_s && right_s)) begin
      req = REQ_HAZ;
    end else if (left_s) begin
      req = REQ_L;
    end else if (right_s) begin
      req = REQ_R;
    end else begin
      req = REQ_NONE;
    end
    return req;
  endfunction

endpackage

// File: rtl/tail_light_seq_step_tick.sv
// Step prescaler: counts 0..DIV-1 and flags the last count of each step.
// clr restarts the count so that every new phase lasts exactly DIV cycles.
module step_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST_CNT);

  // Next count: restart on a phase change or at the end of a step.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tail_light_seq.sv
// Sequential tail-light controller: outward-filling turn pattern on one
// bank of LAMPS lamps, or both banks flashing together for hazards.
// Each pattern step lasts STEP_DIV clocks. Lamp outputs are registered,
// so nothing combinational runs from the driver inputs to the lamps.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LAMPS    = 3,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  output logic [LAMPS-1:0] l,
  output logic [LAMPS-1:0] r,
  output logic             busy
);

  localparam int POS_W = $clog2(LAMPS + 1);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LAMPS);
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);

  state_e           state_q;
  state_e           state_d;
  logic [POS_W-1:0] pos_q;
  logic [POS_W-1:0] pos_d;

  req_e             req_s;
  state_e           start_state_s;
  logic [POS_W-1:0] start_pos_s;
  logic             tick_s;
  logic             clr_s;

  logic [LAMPS-1:0] mask_s;
  logic [LAMPS-1:0] l_d;
  logic [LAMPS-1:0] r_d;
  logic             busy_d;
  logic [LAMPS-1:0] l_q;
  logic [LAMPS-1:0] r_q;
  logic             busy_q;

  // Resolve the three driver controls into a single prioritised request.
  always_comb begin
    req_s = decode_req(left, right, hazard);
  end

  // Where a fresh request leads: shared by IDLE, DARK and HAZ_OFF.
  always_comb begin
    start_state_s = IDLE;
    start_pos_s   = '0;
    case (req_s)
      REQ_HAZ: begin
        start_state_s = HAZ_ON;
        start_pos_s   = '0;
      end
      REQ_L: begin
        start_state_s = LEFT;
        start_pos_s   = POS_ONE;
      end
      REQ_R: begin
        start_state_s = RIGHT;
        start_pos_s   = POS_ONE;
      end
      default: begin
        start_state_s = IDLE;
        start_pos_s   = '0;
      end
    endcase
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      IDLE: begin
        state_d = start_state_s;
        pos_d   = start_pos_s;
      end
      LEFT, RIGHT: begin
        // Turn direction changes are ignored; only hazard interrupts.
        if (req_s == REQ_HAZ) begin
          state_d = HAZ_ON;
          pos_d   = '0;
        end else if (tick_s) begin
          if (pos_q < LAST_POS) begin
            pos_d = pos_q + POS_ONE;
          end else begin
            state_d = DARK;
            pos_d   = '0;
          end
        end else begin
          state_d = state_q;
          pos_d   = pos_q;
        end
      end
      DARK: begin
        if (req_s == REQ_HAZ) begin
          state_d = HAZ_ON;
          pos_d   = '0;
        end else if (tick_s) begin
          state_d = start_state_s;
          pos_d   = start_pos_s;
        end else begin
          state_d = state_q;
          pos_d   = pos_q;
        end
      end
      HAZ_ON: begin
        // The off half always follows, so a flash is never cut short.
        if (tick_s) begin
          state_d = HAZ_OFF;
          pos_d   = '0;
        end else begin
          state_d = state_q;
          pos_d   = pos_q;
        end
      end
      HAZ_OFF: begin
        if (tick_s) begin
          state_d = start_state_s;
          pos_d   = start_pos_s;
        end else begin
          state_d = state_q;
          pos_d   = pos_q;
        end
      end
      default: begin
        state_d = IDLE;
        pos_d   = '0;
      end
    endcase
  end

  // Any change of phase restarts the step prescaler.
  always_comb begin
    clr_s = (state_d != state_q) || (pos_d != pos_q);
  end

  step_tick #(
    .DIV (STEP_DIV)
  ) u_step_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Thermometer mask: the innermost pos lamps are lit.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < LAMPS; i++) begin
      mask_s[i] = (i < int'(pos_d));
    end
  end

  // Lamp and busy values for the state being entered.
  always_comb begin
    l_d    = '0;
    r_d    = '0;
    busy_d = (state_d != IDLE);
    case (state_d)
      LEFT: begin
        l_d = mask_s;
      end
      RIGHT: begin
        r_d = mask_s;
      end
      HAZ_ON: begin
        l_d = '1;
        r_d = '1;
      end
      default: begin
        l_d = '0;
        r_d = '0;
      end
    endcase
  end

  // State, position and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      l_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      l_q     <= l_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
    end
  end

  assign l    = l_q;
  assign r    = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_tail_light_seq.sv
// Bench for tail_light_seq: four instances with different LAMPS/STEP_DIV,
// a phase-level reference model checked every cycle, plus literal
// expectations taken straight from the intended lamp patterns.
module tb_tail_light_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] rst_v;
  logic [3:0] left_v;
  logic [3:0] right_v;
  logic [3:0] haz_v;

  logic [2:0] l0, r0;
  logic [3:0] l1, r1;
  logic [2:0] l2, r2;
  logic [0:0] l3, r3;
  logic       b0, b1, b2, b3;

  int n_checks = 0;
  int n_errors = 0;

  tail_light_seq #(.LAMPS(3), .STEP_DIV(1)) u0 (
    .clk(clk), .rst(rst_v[0]), .left(left_v[0]), .right(right_v[0]),
    .hazard(haz_v[0]), .l(l0), .r(r0), .busy(b0));
  tail_light_seq #(.LAMPS(4), .STEP_DIV(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .left(left_v[1]), .right(right_v[1]),
    .hazard(haz_v[1]), .l(l1), .r(r1), .busy(b1));
  tail_light_seq #(.LAMPS(3), .STEP_DIV(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .left(left_v[2]), .right(right_v[2]),
    .hazard(haz_v[2]), .l(l2), .r(r2), .busy(b2));
  tail_light_seq #(.LAMPS(1), .STEP_DIV(1)) u3 (
    .clk(clk), .rst(rst_v[3]), .left(left_v[3]), .right(right_v[3]),
    .hazard(haz_v[3]), .l(l3), .r(r3), .busy(b3));

  // Reference model: what each lamp bank is doing and how far through it.
  localparam int MD_IDLE = 0;
  localparam int MD_TURN_L = 1;
  localparam int MD_TURN_R = 2;
  localparam int MD_DARK = 3;
  localparam int MD_FLASH_ON = 4;
  localparam int MD_FLASH_OFF = 5;

  int m_mode [4];
  int m_lit  [4];
  int m_age  [4];

  function automatic int lamps_of(input int k);
    case (k)
      0: return 3;
      1: return 4;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int div_of(input int k);
    case (k)
      0: return 1;
      1: return 3;
      2: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int act_l(input int k);
    case (k)
      0: return int'(l0);
      1: return int'(l1);
      2: return int'(l2);
      default: return int'(l3);
    endcase
  endfunction

  function automatic int act_r(input int k);
    case (k)
      0: return int'(r0);
      1: return int'(r1);
      2: return int'(r2);
      default: return int'(r3);
    endcase
  endfunction

  function automatic int act_b(input int k);
    case (k)
      0: return int'(b0);
      1: return int'(b1);
      2: return int'(b2);
      default: return int'(b3);
    endcase
  endfunction

  function automatic int exp_l(input int k);
    if (m_mode[k] == MD_TURN_L) return (1 << m_lit[k]) - 1;
    if (m_mode[k] == MD_FLASH_ON) return (1 << lamps_of(k)) - 1;
    return 0;
  endfunction

  function automatic int exp_r(input int k);
    if (m_mode[k] == MD_TURN_R) return (1 << m_lit[k]) - 1;
    if (m_mode[k] == MD_FLASH_ON) return (1 << lamps_of(k)) - 1;
    return 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pick what a fresh request starts (anything idle-ish ends in IDLE).
  task automatic begin_request(input int k, output int md, output int lit);
    if (haz_v[k] || (left_v[k] && right_v[k])) begin
      md = MD_FLASH_ON; lit = 0;
    end else if (left_v[k]) begin
      md = MD_TURN_L; lit = 1;
    end else if (right_v[k]) begin
      md = MD_TURN_R; lit = 1;
    end else begin
      md = MD_IDLE; lit = 0;
    end
  endtask

  // Predict the phase after the coming rising edge from current inputs.
  task automatic advance(input int k);
    int md;
    int lit;
    bit step_done;
    bit haz_req;
    md = m_mode[k];
    lit = m_lit[k];
    step_done = (m_age[k] + 1 >= div_of(k));
    haz_req = haz_v[k] || (left_v[k] && right_v[k]);
    if (rst_v[k]) begin
      m_mode[k] = MD_IDLE; m_lit[k] = 0; m_age[k] = 0;
      return;
    end
    case (m_mode[k])
      MD_IDLE: begin_request(k, md, lit);
      MD_TURN_L, MD_TURN_R: begin
        if (haz_req) begin md = MD_FLASH_ON; lit = 0; end
        else if (step_done) begin
          if (lit < lamps_of(k)) lit = lit + 1;
          else begin md = MD_DARK; lit = 0; end
        end
      end
      MD_DARK: begin
        if (haz_req) begin md = MD_FLASH_ON; lit = 0; end
        else if (step_done) begin_request(k, md, lit);
      end
      MD_FLASH_ON: if (step_done) md = MD_FLASH_OFF;
      default: if (step_done) begin_request(k, md, lit);
    endcase
    if (md != m_mode[k] || lit != m_lit[k] || step_done) m_age[k] = 0;
    else m_age[k] = m_age[k] + 1;
    m_mode[k] = md;
    m_lit[k] = lit;
  endtask

  // One clock: predict, let the edge happen, compare on the falling edge.
  task automatic cyc();
    for (int k = 0; k < 4; k++) advance(k);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u%0d.l", k), act_l(k), exp_l(k));
      chk($sformatf("u%0d.r", k), act_r(k), exp_r(k));
      chk($sformatf("u%0d.busy", k), act_b(k), (m_mode[k] != MD_IDLE) ? 1 : 0);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  int busy_cnt;

  initial begin
    for (int k = 0; k < 4; k++) begin
      m_mode[k] = MD_IDLE; m_lit[k] = 0; m_age[k] = 0;
    end
    rst_v = 4'b1111; left_v = 4'b0000; right_v = 4'b0000; haz_v = 4'b0000;
    run(2);
    rst_v = 4'b0000;
    chk("reset.l0", int'(l0), 0);
    chk("reset.r0", int'(r0), 0);
    chk("reset.busy0", int'(b0), 0);

    // Legacy 4-cycle left pattern.
    left_v[0] = 1'b1;
    cyc(); chk("t1.l=001", int'(l0), 3'b001);
    cyc(); chk("t1.l=011", int'(l0), 3'b011);
    cyc(); chk("t1.l=111", int'(l0), 3'b111);
    cyc(); chk("t1.l=000", int'(l0), 3'b000); chk("t1.dark_busy", int'(b0), 1);
    cyc(); chk("t1.l=001_again", int'(l0), 3'b001); chk("t1.r", int'(r0), 0);
    left_v[0] = 1'b0;
    run(4); chk("t1.idle", int'(b0), 0);

    // Both stalks -> hazard; dropping right mid-flash finishes the pair.
    left_v[0] = 1'b1; right_v[0] = 1'b1;
    cyc(); chk("t3.on.l", int'(l0), 3'b111); chk("t3.on.r", int'(r0), 3'b111);
    cyc(); chk("t3.off.l", int'(l0), 3'b000);
    cyc(); chk("t3.on2.r", int'(r0), 3'b111);
    right_v[0] = 1'b0;
    cyc(); chk("t3.off2.l", int'(l0), 3'b000); chk("t3.off2.r", int'(r0), 3'b000);
    cyc(); chk("t3.left_start", int'(l0), 3'b001);
    left_v[0] = 1'b0;
    run(5); chk("t3.idle", int'(b0), 0);

    // Single right pulse, 4 lamps, 3 clocks per step.
    right_v[1] = 1'b1;
    cyc();
    right_v[1] = 1'b0;
    busy_cnt = int'(b1);
    chk("t2.r@0", int'(r1), 4'b0001);
    for (int i = 1; i < 20; i++) begin
      cyc();
      busy_cnt += int'(b1);
      if (i == 2) chk("t2.r@2", int'(r1), 4'b0001);
      if (i == 3) chk("t2.r@3", int'(r1), 4'b0011);
      if (i == 11) chk("t2.r@11", int'(r1), 4'b1111);
      if (i == 12) chk("t2.r@12", int'(r1), 4'b0000);
      if (i == 15) chk("t2.idle@15", int'(b1), 0);
    end
    chk("t2.busy_cycles", busy_cnt, 15);

    // Hazard pre-empts a slow left sequence.
    left_v[2] = 1'b1;
    cyc(); chk("t4.l=001", int'(l2), 3'b001);
    cyc();
    cyc(); chk("t4.l=011", int'(l2), 3'b011);
    haz_v[2] = 1'b1;
    cyc(); chk("t4.on1", int'(l2), 3'b111); chk("t4.on1.r", int'(r2), 3'b111);
    cyc(); chk("t4.on2", int'(l2), 3'b111);
    cyc(); chk("t4.off1", int'(l2), 3'b000);
    haz_v[2] = 1'b0; left_v[2] = 1'b0;
    cyc(); chk("t4.off2.busy", int'(b2), 1);
    cyc(); chk("t4.idle", int'(b2), 0);

    // Synchronous reset in the middle of a right sequence.
    right_v[1] = 1'b1;
    run(4); chk("t5.r=0011", int'(r1), 4'b0011);
    rst_v[1] = 1'b1;
    cyc(); chk("t5.rst.r", int'(r1), 4'b0000); chk("t5.rst.busy", int'(b1), 0);
    rst_v[1] = 1'b0;
    cyc(); chk("t5.restart", int'(r1), 4'b0001);
    right_v[1] = 1'b0;
    run(16); chk("t5.idle", int'(b1), 0);

    // One lamp per side.
    left_v[3] = 1'b1;
    cyc(); chk("t6.l=1", int'(l3), 1);
    cyc(); chk("t6.l=0", int'(l3), 0);
    cyc(); chk("t6.l=1b", int'(l3), 1); chk("t6.r", int'(r3), 0);
    cyc(); chk("t6.l=0b", int'(l3), 0);
    left_v[3] = 1'b0;
    run(2); chk("t6.idle", int'(b3), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
